palette_lut: RTL

- Runtime-programmable colour palette for sprite and background rendering.
- Replaces fixed per-screen combinational palettes with one register-based lookup table.
- Adds a 2-stage registered lookup pipeline and a brightness fade engine for screen transitions.
- Sits between sprite/background index generators and the VGA colour mux.

---
 rtl/palette_pkg.sv | 38 +++
 rtl/palette_scale.sv | 21 ++
 rtl/palette_lut.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup block.
// Optional feature macro: PALETTE_TRANSPARENT_EN (see palette_lut).
package palette_pkg;

  // Fade engine states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fade_state_t;

  // Channel width of the stock palette constants below
  localparam int PAL_CH_W = 4;

  // One palette colour, packed {r, g, b}
  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  // Full brightness: level == 2**ch_w scales a channel by exactly 1
  function automatic int lvl_max(input int ch_w);
    return 1 << ch_w;
  endfunction

  // Default end-screen palette; the loader writes these after reset
  localparam rgb_t END_SCREEN [8] = '{
    '{4'h0, 4'h0, 4'h0},
    '{4'hE, 4'h7, 4'h9},
    '{4'h1, 4'h6, 4'h9},
    '{4'hF, 4'hF, 4'hF},
    '{4'hF, 4'h0, 4'h0},
    '{4'h0, 4'hF, 4'h0},
    '{4'h0, 4'h0, 4'hF},
    '{4'h8, 4'h8, 4'h8}
  };

endpackage

// File: rtl/palette_scale.sv
// Scales one colour channel by the current brightness level:
// scaled = floor(ch * level / 2**CH_W). level = 2**CH_W is identity.
module palette_scale
  import palette_pkg::*;
#(
  parameter int CH_W = 4
) (
  input  logic [CH_W-1:0] ch,
  input  logic [CH_W:0]   level,
  output logic [CH_W-1:0] scaled
);

  logic [2*CH_W:0] prod;

  // Full-width product, then drop the fractional bits (floor)
  always_comb begin
    prod   = {{(CH_W+1){1'b0}}, ch} * {{CH_W{1'b0}}, level};
    scaled = CH_W'(prod >> CH_W);
  end

endmodule

// File: rtl/palette_lut.sv
// Runtime-programmable colour palette with a 2-stage lookup pipeline and a
// brightness fade engine.
// Optional feature macro: PALETTE_TRANSPARENT_EN adds a 'transparent' output
// that flags index 0 and blanks its colour.
//
// Handshake: in_valid/out_valid only, no ready. Every cycle with in_valid
// high is a lookup that is always accepted; its result appears with
// out_valid high exactly two cycles later. Colour outputs hold their last
// value while out_valid is low.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W            = 3,
  parameter int CH_W             = 4,
  parameter int FADE_STEP_CYCLES = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [3*CH_W-1:0]   wr_rgb,
  input  logic                in_valid,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic                fade_start,
  input  logic                fade_dir,
  output logic                fade_busy,
  output fade_state_t         dbg_state,
  output logic [CH_W:0]       level,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue
`ifdef PALETTE_TRANSPARENT_EN
  ,
  output logic                transparent
`endif
);

  localparam int            NENT      = 1 << IDX_W;
  localparam logic [CH_W:0] LVL_MAX_V = (CH_W+1)'(lvl_max(CH_W));
  localparam int            CNT_W     = (FADE_STEP_CYCLES > 1) ? $clog2(FADE_STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_CYCLES - 1);

  logic [3*CH_W-1:0] pal_q [NENT];

  fade_state_t       state_q, state_d;
  logic              dir_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W:0]     level_q;
  logic [CH_W:0]     target;
  logic [CH_W:0]     level_nxt;
  logic              at_target;
  logic              wrap;

  logic              s1_valid;
  logic [3*CH_W-1:0] s1_rgb;
  logic [CH_W-1:0]   r_s, g_s, b_s;
`ifdef PALETTE_TRANSPARENT_EN
  logic              s1_zero;
`endif

  // Palette storage: a write lands at the clock edge, so a same-cycle read sees the old entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NENT; i++) pal_q[i] <= '0;
    end else if (wr_en) begin
      pal_q[wr_idx] <= wr_rgb;
    end
  end

  // Fade step decode: target level and whether this cycle ends a step
  always_comb begin
    target    = dir_q ? '0 : LVL_MAX_V;
    at_target = (level_q == target);
    level_nxt = dir_q ? (level_q - 1'b1) : (level_q + 1'b1);
    wrap      = (state_q == RUN) && !at_target && (cnt_q == CNT_LAST);
  end

  // Fade FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Fade FSM next state: leave RUN in the cycle the level lands on its target
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fade_start) state_d = RUN;
      RUN:  if (at_target || (wrap && (level_nxt == target))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Fade FSM outputs
  always_comb begin
    fade_busy = (state_q == RUN);
    dbg_state = state_q;
    level     = level_q;
  end

  // Fade datapath: latch direction on start, count cycles per level, step level on wrap
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      level_q <= LVL_MAX_V;
    end else if ((state_q == IDLE) && fade_start) begin
      dir_q <= fade_dir;
      cnt_q <= '0;
    end else if ((state_q == RUN) && !at_target) begin
      if (wrap) begin
        cnt_q   <= '0;
        level_q <= level_nxt;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: register the table read and the request valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
`ifdef PALETTE_TRANSPARENT_EN
      s1_zero  <= 1'b0;
`endif
    end else begin
      s1_valid <= in_valid;
      s1_rgb   <= pal_q[in_idx];
`ifdef PALETTE_TRANSPARENT_EN
      s1_zero  <= (in_idx == '0);
`endif
    end
  end

  palette_scale #(.CH_W(CH_W)) u_scale_r (.ch(s1_rgb[3*CH_W-1:2*CH_W]), .level(level_q), .scaled(r_s));
  palette_scale #(.CH_W(CH_W)) u_scale_g (.ch(s1_rgb[2*CH_W-1:CH_W]),   .level(level_q), .scaled(g_s));
  palette_scale #(.CH_W(CH_W)) u_scale_b (.ch(s1_rgb[CH_W-1:0]),        .level(level_q), .scaled(b_s));

  // Stage 2: register scaled colour using the level current in this stage
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
`ifdef PALETTE_TRANSPARENT_EN
      transparent <= 1'b0;
`endif
    end else begin
      out_valid <= s1_valid;
`ifdef PALETTE_TRANSPARENT_EN
      transparent <= s1_valid && s1_zero;
      if (s1_valid) begin
        red   <= s1_zero ? '0 : r_s;
        green <= s1_zero ? '0 : g_s;
        blue  <= s1_zero ? '0 : b_s;
      end
`else
      if (s1_valid) begin
        red   <= r_s;
        green <= g_s;
        blue  <= b_s;
      end
`endif
    end
  end

endmodule
